// File: rtl/simon_engine_if.sv
// Purpose : player-facing bus of the Simon memory-game engine.
// Latency : none, this is a plain signal bundle.
// Backpressure: none; enter is a one-cycle strobe and ack/err are one-cycle pulses.
//
// Signals
//   pattern   player key/switch vector (one-hot when legal)
//   enter     single-cycle strobe, pattern is sampled in the same cycle
//   leds      key LEDs
//   mode_leds 3-bit mode indicator
//   level     stored sequence length
//   score     rounds repeated correctly since reset
//   ack       pulse, the cycle after an accepted enter
//   err       pulse, the cycle after a mismatched guess
interface simon_engine_if #(
    parameter int W     = 4,
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  pattern;
    logic          enter;
    logic [W-1:0]  leds;
    logic [2:0]    mode_leds;
    logic [LW-1:0] level;
    logic [LW-1:0] score;
    logic          ack;
    logic          err;

    // Player / test side.
    modport master (
        output pattern,
        output enter,
        input  leds,
        input  mode_leds,
        input  level,
        input  score,
        input  ack,
        input  err
    );

    // Engine side.
    modport slave (
        input  pattern,
        input  enter,
        output leds,
        output mode_leds,
        output level,
        output score,
        output ack,
        output err
    );
endinterface

// File: rtl/simon_engine.sv
// Purpose : Simon memory game; grows a sequence, plays it back, checks the repeat.
// Latency : ack/err one cycle after the enter strobe; playback lasts len*HOLD cycles.
// Backpressure: none; enter strobes that are illegal or arrive in a busy state are dropped.
//
// Ports
//   clk     clock, rising edge
//   rst     synchronous active-high reset, beats every other event in the cycle
//   io_bus  simon_engine_if slave: pattern/enter in, leds/mode_leds/level/score/ack/err out
module simon_engine #(
    parameter int W     = 4,
    parameter int DEPTH = 16,
    parameter int HOLD  = 4
) (
    input  logic         clk,
    input  logic         rst,
    simon_engine_if.slave io_bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [2:0] {
        S_INPUT    = 3'd0,
        S_PLAYBACK = 3'd1,
        S_REPEAT   = 3'd2,
        S_DONE     = 3'd3,
        S_WIN      = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [W-1:0]  r_mem [DEPTH];
    logic [LW-1:0] r_len;
    logic [IW-1:0] r_idx;
    logic [TW-1:0] r_timer;
    logic [LW-1:0] r_score;
    logic          r_ack;
    logic          r_err;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic          w_legal;
    logic          w_accept;
    logic          w_full;
    logic          w_idx_last;
    logic          w_hold_end;
    logic [W-1:0]  w_cur;
    logic          w_match;
    logic          w_mem_we;
    logic [W-1:0]  w_leds;
    logic [2:0]    w_mode;

    // Only a single pressed key counts as a guess; chords and empty
    // vectors are ignored everywhere.
    assign w_legal    = $onehot(io_bus.pattern);
    assign w_accept   = io_bus.enter && w_legal;
    assign w_full     = (r_len == LW'(DEPTH));
    assign w_idx_last = (LW'(r_idx) == (r_len - LW'(1)));
    assign w_hold_end = (r_timer == TW'(HOLD - 1));
    assign w_cur      = r_mem[r_idx];
    assign w_match    = (io_bus.pattern == w_cur);

    // The full check is redundant with the REPEAT->WIN exit, but keeps
    // the write address in range should len ever reach DEPTH in INPUT.
    assign w_mem_we   = !rst && (r_state == S_INPUT) && w_accept && !w_full;

    // ------------------------------------------------------------------
    // Sequence memory: never reset; len=0 makes old entries unreachable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_len[IW-1:0]] <= io_bus.pattern;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INPUT;
            r_len   <= '0;
            r_idx   <= '0;
            r_timer <= '0;
            r_score <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // ack/err are single-cycle pulses; the default clears them.
            r_ack <= 1'b0;
            r_err <= 1'b0;

            case (r_state)
                S_INPUT: begin
                    if (w_accept && !w_full) begin
                        r_len   <= r_len + LW'(1);
                        r_idx   <= '0;
                        r_timer <= '0;
                        r_ack   <= 1'b1;
                        r_state <= S_PLAYBACK;
                    end
                end

                // PLAYBACK and DONE share the stepping logic: each entry is
                // shown for HOLD cycles. PLAYBACK leaves after the last
                // entry, DONE wraps around forever.
                S_PLAYBACK, S_DONE: begin
                    if (w_hold_end) begin
                        r_timer <= '0;
                        if (w_idx_last) begin
                            r_idx <= '0;
                            if (r_state == S_PLAYBACK) begin
                                r_state <= S_REPEAT;
                            end
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                S_REPEAT: begin
                    if (w_accept) begin
                        if (w_match) begin
                            r_ack <= 1'b1;
                            if (w_idx_last) begin
                                r_score <= r_score + LW'(1);
                                r_idx   <= '0;
                                r_state <= w_full ? S_WIN : S_INPUT;
                            end else begin
                                r_idx <= r_idx + IW'(1);
                            end
                        end else begin
                            r_err   <= 1'b1;
                            r_idx   <= '0;
                            r_timer <= '0;
                            r_state <= S_DONE;
                        end
                    end
                end

                S_WIN: begin
                    // Terminal until reset.
                end

                default: begin
                    r_state <= S_INPUT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_leds = '0;
        w_mode = 3'b001;
        case (r_state)
            S_INPUT: begin
                w_leds = io_bus.pattern;
                w_mode = 3'b001;
            end
            S_PLAYBACK: begin
                w_leds = w_cur;
                w_mode = 3'b010;
            end
            S_REPEAT: begin
                w_leds = io_bus.pattern;
                w_mode = 3'b100;
            end
            S_DONE: begin
                w_leds = w_cur;
                w_mode = 3'b111;
            end
            S_WIN: begin
                w_leds = '1;
                w_mode = 3'b101;
            end
            default: begin
                w_leds = '0;
                w_mode = 3'b001;
            end
        endcase
    end

    assign io_bus.leds      = w_leds;
    assign io_bus.mode_leds = w_mode;
    assign io_bus.level     = r_len;
    assign io_bus.score     = r_score;
    assign io_bus.ack       = r_ack;
    assign io_bus.err       = r_err;

endmodule

// File: tb/tb_simon_engine.sv
// Purpose : scoreboard bench for simon_engine (default build and a DEPTH=2 build).
// Latency : expected ack/err events are queued at stimulus time, popped by monitors.
// Backpressure: none; every wait on the design is cycle-bounded.
module tb_simon_engine;
    logic clk;
    logic rst0;
    logic rst1;

    int n_vec = 0;
    int n_err = 0;

    simon_engine_if #(.W(4), .DEPTH(16)) b0 ();
    simon_engine_if #(.W(4), .DEPTH(2))  b1 ();

    simon_engine #(.W(4), .DEPTH(16), .HOLD(4)) dut0 (
        .clk    (clk),
        .rst    (rst0),
        .io_bus (b0)
    );

    simon_engine #(.W(4), .DEPTH(2), .HOLD(4)) dut1 (
        .clk    (clk),
        .rst    (rst1),
        .io_bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1);
    end

    typedef struct {
        bit is_err;
        int lvl;
        int sc;
        int mode;
    } evt_t;

    evt_t q0[$];
    evt_t q1[$];

    // ------------------------------------------------------------------
    // Scoreboard monitors: one pop per ack/err cycle.
    // ------------------------------------------------------------------
    task automatic check_evt(input int d, input logic a, input logic e,
                             input int lvl, input int sc, input int mode);
        evt_t x;
        n_vec++;
        if (d == 0 ? (q0.size() == 0) : (q1.size() == 0)) begin
            n_err++;
            $display("FAIL evt_unexpected dut%0d: got ack=%0b err=%0b with nothing expected", d, a, e);
            return;
        end
        x = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (a !== !x.is_err || e !== x.is_err || lvl != x.lvl || sc != x.sc || mode != x.mode) begin
            n_err++;
            $display("FAIL evt dut%0d: got ack=%0b err=%0b level=%0d score=%0d mode=%03b, expected ack=%0b err=%0b level=%0d score=%0d mode=%03b",
                     d, a, e, lvl, sc, mode[2:0], !x.is_err, x.is_err, x.lvl, x.sc, x.mode[2:0]);
        end
    endtask

    always @(negedge clk) begin
        if (b0.ack === 1'b1 || b0.err === 1'b1)
            check_evt(0, b0.ack, b0.err, int'(b0.level), int'(b0.score), int'(b0.mode_leds));
    end

    always @(negedge clk) begin
        if (b1.ack === 1'b1 || b1.err === 1'b1)
            check_evt(1, b1.ack, b1.err, int'(b1.level), int'(b1.score), int'(b1.mode_leds));
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic expect_evt(input int d, input bit is_err, input int lvl, input int sc, input int mode);
        evt_t x;
        x.is_err = is_err;
        x.lvl    = lvl;
        x.sc     = sc;
        x.mode   = mode;
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic set_in(input int d, input logic [3:0] p, input logic en);
        if (d == 0) begin
            b0.pattern = p;
            b0.enter   = en;
        end else begin
            b1.pattern = p;
            b1.enter   = en;
        end
    endtask

    task automatic press(input int d, input logic [3:0] p);
        set_in(d, p, 1'b1);
        tick();
        set_in(d, p, 1'b0);
    endtask

    function automatic int mode_of(input int d);
        return (d == 0) ? int'(b0.mode_leds) : int'(b1.mode_leds);
    endfunction

    function automatic int leds_of(input int d);
        return (d == 0) ? int'(b0.leds) : int'(b1.leds);
    endfunction

    function automatic int level_of(input int d);
        return (d == 0) ? int'(b0.level) : int'(b1.level);
    endfunction

    function automatic int score_of(input int d);
        return (d == 0) ? int'(b0.score) : int'(b1.score);
    endfunction

    // Cycles until mode_leds shows m; a timeout shows up as a mode miscompare.
    task automatic wait_mode(input int d, input int m, input int budget, output int cyc);
        cyc = 0;
        while (mode_of(d) != m && cyc < budget) begin
            tick();
            cyc++;
        end
        chk("wait_mode", mode_of(d), m);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int c;
        logic [3:0] seq [3];
        seq[0] = 4'b0001;
        seq[1] = 4'b0010;
        seq[2] = 4'b0100;

        rst0 = 1'b1;
        rst1 = 1'b1;
        set_in(0, 4'b0000, 1'b0);
        set_in(1, 4'b0000, 1'b0);
        repeat (2) tick();
        rst0 = 1'b0;
        tick();

        // Reset state.
        chk("rst_mode",  mode_of(0), 3'b001);
        chk("rst_level", level_of(0), 0);
        chk("rst_score", score_of(0), 0);
        chk("rst_ack",   int'(b0.ack), 0);
        chk("rst_err",   int'(b0.err), 0);

        // Illegal patterns are ignored in INPUT.
        press(0, 4'b0110);
        chk("illegal2_level", level_of(0), 0);
        chk("illegal2_mode",  mode_of(0), 3'b001);
        press(0, 4'b0000);
        chk("illegal0_level", level_of(0), 0);
        chk("illegal0_mode",  mode_of(0), 3'b001);

        // First round: 0100, playback exactly 4 cycles.
        expect_evt(0, 0, 1, 0, 3'b010);
        press(0, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            chk("pb1_mode", mode_of(0), 3'b010);
            chk("pb1_leds", leds_of(0), 4'b0100);
            tick();
        end
        chk("pb1_to_repeat", mode_of(0), 3'b100);
        set_in(0, 4'b1000, 1'b0);
        #1;
        chk("repeat_passthru", leds_of(0), 4'b1000);

        // Two-round game from a fresh reset.
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        chk("rst2_level", level_of(0), 0);
        expect_evt(0, 0, 1, 0, 3'b010);
        press(0, 4'b0001);
        wait_mode(0, 3'b100, 40, c);
        chk("pb_len1_cycles", c, 4);
        expect_evt(0, 0, 1, 1, 3'b001);
        press(0, 4'b0001);
        expect_evt(0, 0, 2, 1, 3'b010);
        press(0, 4'b0010);
        for (int i = 0; i < 8; i++) begin
            chk("pb2_mode", mode_of(0), 3'b010);
            chk("pb2_leds", leds_of(0), (i < 4) ? 4'b0001 : 4'b0010);
            tick();
        end
        chk("pb2_to_repeat", mode_of(0), 3'b100);
        // Back-to-back strobes on consecutive cycles.
        expect_evt(0, 0, 2, 1, 3'b100);
        expect_evt(0, 0, 2, 2, 3'b001);
        set_in(0, 4'b0001, 1'b1);
        tick();
        set_in(0, 4'b0010, 1'b1);
        tick();
        set_in(0, 4'b0010, 1'b0);
        chk("round2_score", score_of(0), 2);
        chk("round2_mode",  mode_of(0), 3'b001);

        // Third entry, then a wrong guess leads to DONE replay.
        expect_evt(0, 0, 3, 2, 3'b010);
        press(0, 4'b0100);
        wait_mode(0, 3'b100, 60, c);
        chk("pb_len3_cycles", c, 12);
        expect_evt(0, 1, 3, 2, 3'b111);
        press(0, 4'b1000);
        for (int i = 0; i < 16; i++) begin
            chk("done_mode", mode_of(0), 3'b111);
            chk("done_leds", leds_of(0), int'(seq[(i / 4) % 3]));
            tick();
        end
        press(0, 4'b0001);
        chk("done_hold_mode",  mode_of(0), 3'b111);
        chk("done_hold_level", level_of(0), 3);

        // Reset coincident with a correct guess in REPEAT.
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        expect_evt(0, 0, 1, 0, 3'b010);
        press(0, 4'b0001);
        wait_mode(0, 3'b100, 40, c);
        rst0 = 1'b1;
        set_in(0, 4'b0001, 1'b1);
        tick();
        rst0 = 1'b0;
        set_in(0, 4'b0001, 1'b0);
        chk("rstenter_mode",  mode_of(0), 3'b001);
        chk("rstenter_level", level_of(0), 0);
        chk("rstenter_score", score_of(0), 0);
        chk("rstenter_ack",   int'(b0.ack), 0);
        chk("rstenter_err",   int'(b0.err), 0);

        // DEPTH=2 build: two correct rounds reach WIN.
        rst1 = 1'b0;
        tick();
        chk("d2_rst_mode", mode_of(1), 3'b001);
        expect_evt(1, 0, 1, 0, 3'b010);
        press(1, 4'b0001);
        wait_mode(1, 3'b100, 40, c);
        chk("d2_pb1_cycles", c, 4);
        expect_evt(1, 0, 1, 1, 3'b001);
        press(1, 4'b0001);
        expect_evt(1, 0, 2, 1, 3'b010);
        press(1, 4'b1000);
        wait_mode(1, 3'b100, 40, c);
        chk("d2_pb2_cycles", c, 8);
        expect_evt(1, 0, 2, 1, 3'b100);
        press(1, 4'b0001);
        expect_evt(1, 0, 2, 2, 3'b101);
        press(1, 4'b1000);
        tick();
        chk("d2_win_mode",  mode_of(1), 3'b101);
        chk("d2_win_leds",  leds_of(1), 4'b1111);
        chk("d2_win_score", score_of(1), 2);
        press(1, 4'b0100);
        tick();
        chk("d2_win_hold_mode",  mode_of(1), 3'b101);
        chk("d2_win_hold_level", level_of(1), 2);
        chk("d2_win_hold_leds",  leds_of(1), 4'b1111);

        repeat (2) tick();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/simon_engine.md
SIMON_ENGINE -- requirements
Module: simon_engine

Interface
REQ-001 Parameter W, default 4, number of keys/LEDs; the pattern width; SHALL be at least 2.
REQ-002 Parameter DEPTH, default 16, maximum sequence length; SHALL be at least 2.
REQ-003 Parameter HOLD, default 4, clock cycles each playback step is displayed; SHALL be at least 1.
REQ-004 Derived LW = $clog2(DEPTH+1), width of len/score.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 pattern  input  W  key/switch vector from player.
REQ-008 enter  input  1  single-cycle strobe; samples pattern in same cycle.
REQ-009 leds  output  W  key LEDs.
REQ-010 mode_leds  output  3  mode indicator.
REQ-011 level  output  LW  current stored sequence length (len).
REQ-012 score  output  LW  rounds successfully repeated since reset.
REQ-013 ack  output  1  registered pulse: high the cycle after an accepted enter.
REQ-014 err  output  1  registered pulse: high the cycle after a mismatched guess.

Function
REQ-015 Internal: mem[DEPTH] of W bits, len (LW), idx (index), timer (0..HOLD-1), state.
REQ-016 legal SHALL be true when pattern has exactly one bit set; enter with !legal is ignored in all states (no ack, no state change).
REQ-017 States: INPUT, PLAYBACK, REPEAT, DONE, WIN; mode_leds decoded from state: 001, 010, 100, 111, 101 respectively.
REQ-018 leds: INPUT and REPEAT = pattern (combinational pass-through); PLAYBACK and DONE = mem[idx]; WIN = all ones.
REQ-019 INPUT, enter&&legal: mem[len]<=pattern, len<=len+1, idx<=0, timer<=0, ack next cycle, go PLAYBACK.
REQ-020 PLAYBACK: timer increments each cycle; at timer==HOLD-1, timer<=0 and idx advances; if idx==len-1, idx<=0, go REPEAT; enter ignored.
REQ-021 PLAYBACK latency: exactly len*HOLD cycles in state.
REQ-022 REPEAT, enter&&legal&&pattern==mem[idx]: ack next cycle; if idx<len-1, idx<=idx+1.
REQ-023 REPEAT, correct guess at idx==len-1: score<=score+1, idx<=0; go WIN if len==DEPTH, else INPUT.
REQ-024 REPEAT, enter&&legal&&pattern!=mem[idx]: err next cycle, no ack, idx<=0, timer<=0, go DONE.
REQ-025 DONE: replays mem[0..len-1] with HOLD cycles per entry, idx wraps len-1 -> 0 indefinitely; enter ignored; exit only by rst.
REQ-026 WIN: holds; enter ignored; exit only by rst.
REQ-027 ack and err SHALL never be high in the same cycle; each is exactly one cycle wide per event.
REQ-028 len never exceeds DEPTH; no mem write ever occurs with len==DEPTH.
REQ-029 Back-to-back enter strobes in consecutive cycles SHALL each be evaluated against the updated state/idx.

Reset
REQ-030 rst has priority over every other event in the cycle, including a coincident enter.
REQ-031 On rst: state=INPUT, len=0, idx=0, timer=0, score=0, ack=0, err=0; mode_leds=001 next cycle.
REQ-032 mem contents are not cleared; they are unreachable after reset because len=0.
REQ-033 rst mid-PLAYBACK/REPEAT/DONE/WIN returns to INPUT with the same values as REQ-031.

Verification
REQ-034 Defaults; rst, then enter pattern=0100 -> ack 1 cycle later, level=1, mode 010 for 4 cycles with leds=0100, then mode 100.
REQ-035 INPUT, enter pattern=0110 or 0000 -> no ack, level stays 0, mode stays 001.
REQ-036 Two rounds (0001, then 0010); repeat 0001,0010 correctly -> score=2, mode 001; PLAYBACK second round lasts 8 cycles.
REQ-037 REPEAT with mem[0]=0001, enter 1000 -> err pulse, mode 111, leds cycle mem entries every 4 cycles, wrapping.
REQ-038 DEPTH=2: complete two rounds correctly -> mode 101, leds=11..1, score=2; enter ignored.
REQ-039 rst asserted together with enter during REPEAT -> no ack/err, mode 001, level=0, score=0.
